// File: rtl/arashi_pkg.sv
// Shared types and size derivations for the per-thread response buffer.
package arashi_pkg;

    // Thread-id width of the default four-thread configuration.
    localparam int unsigned TID_WIDTH_DEFAULT = 2;

    typedef logic [TID_WIDTH_DEFAULT-1:0] thread_id_t;

    // Number of threads addressed by a thread id of the given width.
    function automatic int unsigned thread_num(input int unsigned tid_width);
        return 32'd1 << tid_width;
    endfunction

    // Per-thread queue depth for a pointer of the given width.
    function automatic int unsigned queue_depth(input int unsigned depth_width);
        return 32'd1 << depth_width;
    endfunction

endpackage

// File: rtl/arashi_rr_arbiter.sv
// Round-robin arbiter: grants at most one requester per cycle. The search
// starts one past the most recent grant and wraps around.
module arashi_rr_arbiter
    import arashi_pkg::*;
#(
    parameter  int unsigned ID_WIDTH = 2,
    localparam int unsigned N        = thread_num(ID_WIDTH)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N-1:0]        req,
    output logic [N-1:0]        grant,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                grant_valid
);

    logic [ID_WIDTH-1:0] prio_q, prio_d;
    logic [ID_WIDTH-1:0] idx;

    // Pick the first requester at or after the priority pointer, wrapping.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch
        // can skip it; a path that leaves a variable unassigned would
        // infer a latch.
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        prio_d      = prio_q;
        idx         = '0;
        for (int i = 0; i < N; i++) begin
            idx = prio_q + ID_WIDTH'(i);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
                grant[idx]  = 1'b1;
            end
        end
        if (grant_valid) begin
            prio_d = grant_id + ID_WIDTH'(1);
        end
    end

    // Priority pointer register; reset gives thread 0 first priority.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so that every
        // flop samples the values from before this edge.
        if (!rstn) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/arashi_resp_buf.sv
// Response buffer: one FIFO per thread in a shared storage array, filled by
// the cache and drained towards the threads through a round-robin arbiter.
module arashi_resp_buf
    import arashi_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH       = 32,
    parameter  int unsigned THREAD_NUM_WIDTH = 2,
    parameter  int unsigned DEPTH_WIDTH      = 3,
    localparam int unsigned THREAD_NUM       = thread_num(THREAD_NUM_WIDTH),
    localparam int unsigned DEPTH            = queue_depth(DEPTH_WIDTH),
    localparam int unsigned CW               = DEPTH_WIDTH + 1
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             cache_valid,
    input  logic [THREAD_NUM_WIDTH-1:0]      cache_tid,
    input  logic [DATA_WIDTH-1:0]            cache2mem,
    output logic                             cache_ready,
    input  logic [THREAD_NUM-1:0]            r_ena,
    input  logic [THREAD_NUM-1:0]            flush,
    output logic [DATA_WIDTH*THREAD_NUM-1:0] data_out,
    output logic [THREAD_NUM-1:0]            r_ready,
    output logic [CW*THREAD_NUM-1:0]         occupancy
);

    localparam int unsigned AW = THREAD_NUM_WIDTH + DEPTH_WIDTH;

    logic [DEPTH_WIDTH-1:0] wptr_q  [THREAD_NUM];
    logic [DEPTH_WIDTH-1:0] wptr_d  [THREAD_NUM];
    logic [DEPTH_WIDTH-1:0] rptr_q  [THREAD_NUM];
    logic [DEPTH_WIDTH-1:0] rptr_d  [THREAD_NUM];
    logic [CW-1:0]          count_q [THREAD_NUM];
    logic [CW-1:0]          count_d [THREAD_NUM];

    logic [DATA_WIDTH*THREAD_NUM-1:0] data_out_q, data_out_d;
    logic [THREAD_NUM-1:0]            r_ready_q, r_ready_d;

    // Shared storage, partitioned by thread: address = {tid, ptr}.
    logic [DATA_WIDTH-1:0] mem [THREAD_NUM*DEPTH];

    logic [THREAD_NUM-1:0]       full, eligible, wr_sel, grant;
    logic [THREAD_NUM_WIDTH-1:0] grant_id;
    logic                        grant_valid;
    logic                        wr_en;
    logic [AW-1:0]               wr_addr, rd_addr;

    // Queue status from registered state only: no pop credit, no bypass.
    always_comb begin
        for (int i = 0; i < THREAD_NUM; i++) begin
            full[i]     = (count_q[i] == CW'(DEPTH));
            eligible[i] = r_ena[i] && (count_q[i] != '0) && !flush[i];
        end
        cache_ready = rstn && !full[cache_tid] && !flush[cache_tid];
        wr_en       = cache_valid && cache_ready;
        for (int i = 0; i < THREAD_NUM; i++) begin
            wr_sel[i] = wr_en && (cache_tid == THREAD_NUM_WIDTH'(i));
        end
        wr_addr = {cache_tid, wptr_q[cache_tid]};
        rd_addr = {grant_id, rptr_q[grant_id]};
    end

    arashi_rr_arbiter #(
        .ID_WIDTH (THREAD_NUM_WIDTH)
    ) u_arb (
        .clk         (clk),
        .rstn        (rstn),
        .req         (eligible),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Next pointers, counts and read data; a flush overrides both the
    // write and the read of its thread.
    always_comb begin
        data_out_d = data_out_q;
        r_ready_d  = grant;
        if (grant_valid) begin
            data_out_d[grant_id*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr];
        end
        for (int i = 0; i < THREAD_NUM; i++) begin
            wptr_d[i]  = wptr_q[i];
            rptr_d[i]  = rptr_q[i];
            count_d[i] = count_q[i];
            if (flush[i]) begin
                wptr_d[i]  = '0;
                rptr_d[i]  = '0;
                count_d[i] = '0;
            end else begin
                if (wr_sel[i]) wptr_d[i] = wptr_q[i] + DEPTH_WIDTH'(1);
                if (grant[i])  rptr_d[i] = rptr_q[i] + DEPTH_WIDTH'(1);
                case ({wr_sel[i], grant[i]})
                    2'b10:   count_d[i] = count_q[i] + CW'(1);
                    2'b01:   count_d[i] = count_q[i] - CW'(1);
                    default: count_d[i] = count_q[i];
                endcase
            end
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < THREAD_NUM; i++) begin
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
                count_q[i] <= '0;
            end
            data_out_q <= '0;
            r_ready_q  <= '0;
        end else begin
            for (int i = 0; i < THREAD_NUM; i++) begin
                wptr_q[i]  <= wptr_d[i];
                rptr_q[i]  <= rptr_d[i];
                count_q[i] <= count_d[i];
            end
            data_out_q <= data_out_d;
            r_ready_q  <= r_ready_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; counts gate every read, so
        // stale contents are never observed and the array can map to RAM.
        if (wr_en) begin
            mem[wr_addr] <= cache2mem;
        end
    end

    assign data_out = data_out_q;
    assign r_ready  = r_ready_q;

    for (genvar i = 0; i < THREAD_NUM; i++) begin : g_occ
        assign occupancy[i*CW +: CW] = count_q[i];
    end

endmodule

// File: tb/tb_arashi_resp_buf.sv
// Directed testbench for arashi_resp_buf (8-bit words, 4 threads, depth 4).
module tb_arashi_resp_buf;
    import arashi_pkg::*;

    localparam int DW  = 8;
    localparam int TW  = 2;
    localparam int DPW = 2;
    localparam int TN  = 4;
    localparam int CW  = DPW + 1;

    logic             clk;
    logic             rstn;
    logic             cache_valid;
    thread_id_t       cache_tid;
    logic [DW-1:0]    cache2mem;
    logic             cache_ready;
    logic [TN-1:0]    r_ena;
    logic [TN-1:0]    flush;
    logic [DW*TN-1:0] data_out;
    logic [TN-1:0]    r_ready;
    logic [CW*TN-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    arashi_resp_buf #(
        .DATA_WIDTH       (DW),
        .THREAD_NUM_WIDTH (TW),
        .DEPTH_WIDTH      (DPW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cache_valid (cache_valid),
        .cache_tid   (cache_tid),
        .cache2mem   (cache2mem),
        .cache_ready (cache_ready),
        .r_ena       (r_ena),
        .flush       (flush),
        .data_out    (data_out),
        .r_ready     (r_ready),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] occ(input int tid);
        return occupancy[tid*CW +: CW];
    endfunction

    function automatic logic [DW-1:0] dat(input int tid);
        return data_out[tid*DW +: DW];
    endfunction

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int tid, input logic [DW-1:0] d);
        cache_valid = 1'b1;
        cache_tid   = thread_id_t'(tid);
        cache2mem   = d;
        step();
        cache_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cache_valid = 1'b1;
        cache_tid = 2'd0;
        cache2mem = 8'h99;
        step();
        step();
        checks++;
        if (r_ready !== 4'b0 || data_out !== '0 || occupancy !== '0) begin
            errors++;
            $display("FAIL reset_outputs: r_ready=%b data_out=%h occupancy=%h, expected all zero",
                     r_ready, data_out, occupancy);
        end
        checks++;
        if (cache_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_cache_ready: got %b expected 0", cache_ready);
        end
        cache_valid = 1'b0;
        rstn = 1'b1;
        step();
        checks++;
        if (occupancy !== '0 || r_ready !== 4'b0) begin
            errors++;
            $display("FAIL reset_release: occupancy=%h r_ready=%b expected zero", occupancy, r_ready);
        end
    endtask

    task automatic test_basic_read();
        push(1, 8'h11);
        push(1, 8'h22);
        checks++;
        if (occ(1) !== 3'd2) begin
            errors++;
            $display("FAIL basic_occ_fill: got %0d expected 2", occ(1));
        end
        r_ena = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (r_ready !== 4'b0010 || dat(1) !== (k == 0 ? 8'h11 : 8'h22) || occ(1) !== 3'(1 - k)) begin
                errors++;
                $display("FAIL basic_read%0d: r_ready=%b data=%h occ=%0d expected 0010 %h %0d",
                         k, r_ready, dat(1), occ(1), (k == 0 ? 8'h11 : 8'h22), 1 - k);
            end
        end
        r_ena = 4'b0;
        step();
        checks++;
        if (r_ready !== 4'b0 || dat(1) !== 8'h22) begin
            errors++;
            $display("FAIL basic_hold: r_ready=%b data=%h expected 0000 22", r_ready, dat(1));
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) push(3, 8'hA0 + 8'(k));
        cache_valid = 1'b1;
        cache_tid = 2'd3;
        cache2mem = 8'hA4;
        #1;
        checks++;
        if (cache_ready !== 1'b0 || occ(3) !== 3'd4) begin
            errors++;
            $display("FAIL full_backpressure: cache_ready=%b occ=%0d expected 0 4", cache_ready, occ(3));
        end
        r_ena = 4'b1000;
        step();
        checks++;
        if (r_ready !== 4'b1000 || dat(3) !== 8'hA0 || occ(3) !== 3'd3 || cache_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_after_pop: r_ready=%b data=%h occ=%0d cache_ready=%b expected 1000 a0 3 1",
                     r_ready, dat(3), occ(3), cache_ready);
        end
        cache_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            step();
            checks++;
            if (r_ready !== 4'b1000 || dat(3) !== 8'hA0 + 8'(k) || occ(3) !== 3'(3 - k)) begin
                errors++;
                $display("FAIL full_drain%0d: r_ready=%b data=%h occ=%0d expected 1000 %h %0d",
                         k, r_ready, dat(3), occ(3), 8'hA0 + 8'(k), 3 - k);
            end
        end
        r_ena = 4'b0;
        step();
    endtask

    task automatic test_round_robin();
        for (int t = 0; t < 4; t++) push(t, 8'hC0 + 8'(t));
        r_ena = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (r_ready !== 4'(1 << k) || dat(k) !== 8'hC0 + 8'(k)) begin
                errors++;
                $display("FAIL rr_seq%0d: r_ready=%b data=%h expected %b %h",
                         k, r_ready, dat(k), 4'(1 << k), 8'hC0 + 8'(k));
            end
        end
        step();
        checks++;
        if (r_ready !== 4'b0) begin
            errors++;
            $display("FAIL rr_idle: r_ready=%b expected 0000", r_ready);
        end
        // Two words on thread 0, one on thread 2: rotation must interleave.
        r_ena = 4'b0;
        push(0, 8'hD0);
        push(0, 8'hD1);
        push(2, 8'hD2);
        r_ena = 4'b0101;
        step();
        checks++;
        if (r_ready !== 4'b0001 || dat(0) !== 8'hD0) begin
            errors++;
            $display("FAIL rr_rot0: r_ready=%b data=%h expected 0001 d0", r_ready, dat(0));
        end
        step();
        checks++;
        if (r_ready !== 4'b0100 || dat(2) !== 8'hD2) begin
            errors++;
            $display("FAIL rr_rot1: r_ready=%b data=%h expected 0100 d2", r_ready, dat(2));
        end
        step();
        checks++;
        if (r_ready !== 4'b0001 || dat(0) !== 8'hD1) begin
            errors++;
            $display("FAIL rr_rot2: r_ready=%b data=%h expected 0001 d1", r_ready, dat(0));
        end
        r_ena = 4'b0;
        step();
    endtask

    task automatic test_no_bypass();
        cache_valid = 1'b1;
        cache_tid = 2'd0;
        cache2mem = 8'h5A;
        r_ena = 4'b0001;
        step();
        cache_valid = 1'b0;
        checks++;
        if (r_ready !== 4'b0 || occ(0) !== 3'd1) begin
            errors++;
            $display("FAIL bypass_first: r_ready=%b occ=%0d expected 0000 1", r_ready, occ(0));
        end
        step();
        checks++;
        if (r_ready !== 4'b0001 || dat(0) !== 8'h5A) begin
            errors++;
            $display("FAIL bypass_second: r_ready=%b data=%h expected 0001 5a", r_ready, dat(0));
        end
        r_ena = 4'b0;
        step();
    endtask

    task automatic test_flush();
        push(0, 8'h77);
        for (int k = 0; k < 3; k++) push(2, 8'hE0 + 8'(k));
        checks++;
        if (occ(2) !== 3'd3) begin
            errors++;
            $display("FAIL flush_fill: occ=%0d expected 3", occ(2));
        end
        cache_valid = 1'b1;
        cache_tid = 2'd2;
        cache2mem = 8'hEE;
        flush = 4'b0100;
        r_ena = 4'b0100;
        #1;
        checks++;
        if (cache_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: cache_ready=%b expected 0", cache_ready);
        end
        step();
        flush = 4'b0;
        cache_valid = 1'b0;
        checks++;
        if (occ(2) !== 3'd0 || r_ready !== 4'b0 || occ(0) !== 3'd1 || dat(2) !== 8'hD2) begin
            errors++;
            $display("FAIL flush_effect: occ2=%0d r_ready=%b occ0=%0d data2=%h expected 0 0000 1 d2",
                     occ(2), r_ready, occ(0), dat(2));
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (r_ready !== 4'b0 || occ(2) !== 3'd0) begin
                errors++;
                $display("FAIL flush_after%0d: r_ready=%b occ2=%0d expected 0000 0", k, r_ready, occ(2));
            end
        end
        r_ena = 4'b0;
    endtask

    task automatic test_reset_mid();
        push(1, 8'h88);
        checks++;
        if (occ(0) !== 3'd1 || occ(1) !== 3'd1) begin
            errors++;
            $display("FAIL rmid_fill: occ0=%0d occ1=%0d expected 1 1", occ(0), occ(1));
        end
        r_ena = 4'b1111;
        rstn = 1'b0;
        step();
        checks++;
        if (r_ready !== 4'b0 || data_out !== '0 || occupancy !== '0 || cache_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_reset: r_ready=%b data_out=%h occupancy=%h cache_ready=%b expected all 0",
                     r_ready, data_out, occupancy, cache_ready);
        end
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (r_ready !== 4'b0 || occupancy !== '0) begin
                errors++;
                $display("FAIL rmid_after%0d: r_ready=%b occupancy=%h expected zero", k, r_ready, occupancy);
            end
        end
        r_ena = 4'b0;
    endtask

    initial begin
        rstn = 1'b0;
        cache_valid = 1'b0;
        cache_tid = 2'd0;
        cache2mem = '0;
        r_ena = '0;
        flush = '0;
        test_reset();
        test_basic_read();
        test_full();
        test_round_robin();
        test_no_bypass();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
